// File: rtl/packet_stats_from_last_if.sv
// Stream-side and record-side signals of the packet statistics block.
// The slave modport is the statistics block itself; the master modport is
// whatever produces beats and consumes records.
interface packet_stats_from_last_if #(
  parameter int width       = 8,
  parameter int sum_width   = 16,
  parameter int count_width = 8
);
  logic                   up_valid;
  logic                   up_last;
  logic [width-1:0]       up_data;
  logic                   down_valid;
  logic                   down_ready;
  logic [sum_width-1:0]   down_sum;
  logic [count_width-1:0] down_count;
  logic [width-1:0]       down_max;
  logic                   down_overflow;

  modport master (
    output up_valid, up_last, up_data, down_ready,
    input  down_valid, down_sum, down_count, down_max, down_overflow
  );

  modport slave (
    input  up_valid, up_last, up_data, down_ready,
    output down_valid, down_sum, down_count, down_max, down_overflow
  );
endinterface

// File: rtl/packet_stats_from_last.sv
// Per-packet statistics over a valid/last beat stream: wrapped sum with
// overflow flag, saturating beat count and maximum beat. One record per
// packet is pushed into a small FIFO on the last beat; records the FIFO
// cannot take are dropped and counted, since the beat source cannot stall.
//
// state    | meaning
// ---------+---------------------------------------------------------
// st_first | next valid beat opens a new packet (seeds the accumulator)
// st_body  | inside a packet; valid beats accumulate into acc_*
module packet_stats_from_last #(
  parameter int width       = 8,
  parameter int sum_width   = 16,
  parameter int count_width = 8,
  parameter int depth       = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  packet_stats_from_last_if.slave bus,
  output logic [count_width-1:0] drop_count
);

  localparam int aw = $clog2(depth);
  localparam logic [aw:0] depth_occ = (aw + 1)'(depth);
  localparam logic [count_width-1:0] cnt_sat = '1;

  typedef enum logic {st_first, st_body} acc_state_t;

  acc_state_t             state;
  logic [sum_width-1:0]   acc_sum;
  logic [count_width-1:0] acc_cnt;
  logic [width-1:0]       acc_max;
  logic                   acc_ovf;

  logic [sum_width:0]     add_full;
  logic [sum_width-1:0]   nxt_sum;
  logic [count_width-1:0] nxt_cnt;
  logic [width-1:0]       nxt_max;
  logic                   nxt_ovf;

  logic [sum_width-1:0]   mem_sum [depth];
  logic [count_width-1:0] mem_cnt [depth];
  logic [width-1:0]       mem_max [depth];
  logic                   mem_ovf [depth];
  logic [aw-1:0]          wr_ptr;
  logic [aw-1:0]          rd_ptr;
  logic [aw:0]            occ;

  logic rec_done;
  logic pop;
  logic push;

  // Record the current beat would produce: seed on an opening beat, else fold in.
  always_comb begin
    add_full = {1'b0, acc_sum} + (sum_width + 1)'(bus.up_data);
    nxt_sum  = add_full[sum_width-1:0];
    nxt_ovf  = acc_ovf | add_full[sum_width];
    nxt_cnt  = (acc_cnt == cnt_sat) ? acc_cnt : acc_cnt + 1'b1;
    nxt_max  = (bus.up_data > acc_max) ? bus.up_data : acc_max;
    if (state == st_first) begin
      nxt_sum = sum_width'(bus.up_data);
      nxt_ovf = 1'b0;
      nxt_cnt = count_width'(1);
      nxt_max = bus.up_data;
    end
  end

  assign rec_done = bus.up_valid & bus.up_last;
  assign pop      = (occ != '0) & bus.down_ready;
  // A full FIFO still takes the record when its head leaves in the same cycle.
  assign push     = rec_done & ((occ < depth_occ) | pop);

  // Accumulator: packet boundary tracking and running statistics.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= st_first;
      acc_sum <= '0;
      acc_cnt <= '0;
      acc_max <= '0;
      acc_ovf <= 1'b0;
    end else if (bus.up_valid) begin
      acc_sum <= nxt_sum;
      acc_cnt <= nxt_cnt;
      acc_max <= nxt_max;
      acc_ovf <= nxt_ovf;
      // A dropped record restarts the packet just like a stored one.
      state   <= bus.up_last ? st_first : st_body;
    end
  end

  // Result FIFO storage, pointers, occupancy and drop counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < depth; i++) begin
        mem_sum[i] <= '0;
        mem_cnt[i] <= '0;
        mem_max[i] <= '0;
        mem_ovf[i] <= 1'b0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      drop_count <= '0;
    end else begin
      if (push) begin
        mem_sum[wr_ptr] <= nxt_sum;
        mem_cnt[wr_ptr] <= nxt_cnt;
        mem_max[wr_ptr] <= nxt_max;
        mem_ovf[wr_ptr] <= nxt_ovf;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        occ <= occ + 1'b1;
      end else if (pop && !push) begin
        occ <= occ - 1'b1;
      end
      if (rec_done && !push && drop_count != cnt_sat) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

  assign bus.down_valid    = (occ != '0);
  assign bus.down_sum      = mem_sum[rd_ptr];
  assign bus.down_count    = mem_cnt[rd_ptr];
  assign bus.down_max      = mem_max[rd_ptr];
  assign bus.down_overflow = mem_ovf[rd_ptr];

endmodule

// File: tb/tb_packet_stats_from_last.sv
// Bench for packet_stats_from_last: two instances (16-bit and 8-bit sums)
// share one stimulus stream and are compared against a packet-level model.
module tb_packet_stats_from_last;

  typedef struct {
    int sum;
    int cnt;
    int mx;
    bit ovf;
  } rec_t;

  logic       clock;
  logic       reset;
  logic [7:0] drop_a;
  logic [7:0] drop_b;

  int n_checks = 0;
  int n_fail   = 0;

  int   beats[$];
  rec_t qa[$];
  rec_t qb[$];
  int   exp_drop_a;
  int   exp_drop_b;

  packet_stats_from_last_if #(.width(8), .sum_width(16), .count_width(8)) ia ();
  packet_stats_from_last_if #(.width(8), .sum_width(8),  .count_width(8)) ib ();

  packet_stats_from_last #(.width(8), .sum_width(16), .count_width(8), .depth(2)) dut_a (
    .clock(clock), .reset(reset), .bus(ia.slave), .drop_count(drop_a)
  );

  packet_stats_from_last #(.width(8), .sum_width(8), .count_width(8), .depth(2)) dut_b (
    .clock(clock), .reset(reset), .bus(ib.slave), .drop_count(drop_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Statistics of the packet held in beats[], as seen with a sw-bit sum.
  function automatic rec_t make_rec(input int sw);
    rec_t   r;
    longint total = 0;
    r.mx = 0;
    foreach (beats[i]) begin
      total += beats[i];
      if (beats[i] > r.mx) r.mx = beats[i];
    end
    r.sum = int'(total % (longint'(1) << sw));
    r.ovf = (total >= (longint'(1) << sw));
    r.cnt = (beats.size() > 255) ? 255 : beats.size();
    return r;
  endfunction

  task automatic drive(input bit v, input bit l, input int d, input bit r);
    ia.up_valid = v; ia.up_last = l; ia.up_data = 8'(d); ia.down_ready = r;
    ib.up_valid = v; ib.up_last = l; ib.up_data = 8'(d); ib.down_ready = r;
  endtask

  // One clock cycle of stimulus; the model advances alongside.
  task automatic step(input bit v, input bit l, input int d, input bit r);
    bit pop_a, pop_b;
    drive(v, l, d, r);
    pop_a = (qa.size() != 0) && r;
    pop_b = (qb.size() != 0) && r;
    if (pop_a) void'(qa.pop_front());
    if (pop_b) void'(qb.pop_front());
    if (v) begin
      beats.push_back(d & 255);
      if (l) begin
        if (qa.size() < 2) qa.push_back(make_rec(16));
        else if (exp_drop_a < 255) exp_drop_a++;
        if (qb.size() < 2) qb.push_back(make_rec(8));
        else if (exp_drop_b < 255) exp_drop_b++;
        beats.delete();
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    beats.delete();
    qa.delete();
    qb.delete();
    exp_drop_a = 0;
    exp_drop_b = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (ia.down_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %0b expected 0", ia.down_valid);
    end
    n_checks++;
    if ({ia.down_sum, ia.down_count, ia.down_max, ia.down_overflow} !== 33'd0) begin
      n_fail++; $display("FAIL reset_data: got sum=%0d cnt=%0d max=%0d ovf=%0b expected all 0",
                         ia.down_sum, ia.down_count, ia.down_max, ia.down_overflow);
    end
    n_checks++;
    if (drop_a !== 8'd0) begin
      n_fail++; $display("FAIL reset_drop: got %0d expected 0", drop_a);
    end
  endtask

  task automatic test_basic();
    do_reset();
    step(1, 0, 3, 1);
    step(1, 0, 5, 1);
    n_checks++;
    if (ia.down_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_early_valid: got %0b expected 0", ia.down_valid);
    end
    step(1, 1, 7, 1);
    n_checks++;
    if (ia.down_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_valid: got %0b expected 1", ia.down_valid);
    end
    n_checks++;
    if (ia.down_sum !== 16'd15 || ia.down_count !== 8'd3 || ia.down_max !== 8'd7 ||
        ia.down_overflow !== 1'b0) begin
      n_fail++; $display("FAIL basic_record: got sum=%0d cnt=%0d max=%0d ovf=%0b expected 15 3 7 0",
                         ia.down_sum, ia.down_count, ia.down_max, ia.down_overflow);
    end
    step(0, 0, 0, 1);
    n_checks++;
    if (ia.down_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_drain: got %0b expected 0", ia.down_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    step(1, 0, 200, 0);
    step(1, 1, 100, 0);
    n_checks++;
    if (ib.down_valid !== 1'b1 || ib.down_sum !== 8'd44 || ib.down_count !== 8'd2 ||
        ib.down_max !== 8'd200 || ib.down_overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_narrow: got v=%0b sum=%0d cnt=%0d max=%0d ovf=%0b expected 1 44 2 200 1",
                         ib.down_valid, ib.down_sum, ib.down_count, ib.down_max, ib.down_overflow);
    end
    n_checks++;
    if (ia.down_sum !== 16'd300 || ia.down_overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_wide: got sum=%0d ovf=%0b expected 300 0",
                         ia.down_sum, ia.down_overflow);
    end
  endtask

  task automatic test_drop();
    do_reset();
    step(1, 1, 1, 0);
    step(1, 1, 2, 0);
    step(1, 1, 3, 0);
    n_checks++;
    if (drop_a !== 8'd1) begin
      n_fail++; $display("FAIL drop_count: got %0d expected 1", drop_a);
    end
    n_checks++;
    if (ia.down_valid !== 1'b1 || ia.down_sum !== 16'd1 || ia.down_count !== 8'd1) begin
      n_fail++; $display("FAIL drop_head1: got v=%0b sum=%0d cnt=%0d expected 1 1 1",
                         ia.down_valid, ia.down_sum, ia.down_count);
    end
    step(0, 0, 0, 1);
    n_checks++;
    if (ia.down_valid !== 1'b1 || ia.down_sum !== 16'd2) begin
      n_fail++; $display("FAIL drop_head2: got v=%0b sum=%0d expected 1 2", ia.down_valid, ia.down_sum);
    end
    step(0, 0, 0, 1);
    n_checks++;
    if (ia.down_valid !== 1'b0 || drop_a !== 8'd1) begin
      n_fail++; $display("FAIL drop_empty: got v=%0b drop=%0d expected 0 1", ia.down_valid, drop_a);
    end
  endtask

  task automatic test_full_pop_push();
    do_reset();
    step(1, 1, 10, 0);
    step(1, 1, 20, 0);
    step(1, 1, 30, 1);
    n_checks++;
    if (drop_a !== 8'd0 || ia.down_valid !== 1'b1 || ia.down_sum !== 16'd20) begin
      n_fail++; $display("FAIL fullpop_head: got drop=%0d v=%0b sum=%0d expected 0 1 20",
                         drop_a, ia.down_valid, ia.down_sum);
    end
    step(0, 0, 0, 1);
    n_checks++;
    if (ia.down_valid !== 1'b1 || ia.down_sum !== 16'd30) begin
      n_fail++; $display("FAIL fullpop_pushed: got v=%0b sum=%0d expected 1 30", ia.down_valid, ia.down_sum);
    end
    step(0, 0, 0, 1);
    n_checks++;
    if (ia.down_valid !== 1'b0) begin
      n_fail++; $display("FAIL fullpop_empty: got %0b expected 0", ia.down_valid);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    step(1, 0, 9, 0);
    step(1, 0, 4, 0);
    do_reset();
    step(1, 1, 6, 0);
    n_checks++;
    if (ia.down_valid !== 1'b1 || ia.down_sum !== 16'd6 || ia.down_count !== 8'd1 ||
        ia.down_max !== 8'd6 || ia.down_overflow !== 1'b0) begin
      n_fail++; $display("FAIL midreset_record: got v=%0b sum=%0d cnt=%0d max=%0d ovf=%0b expected 1 6 1 6 0",
                         ia.down_valid, ia.down_sum, ia.down_count, ia.down_max, ia.down_overflow);
    end
    step(0, 0, 0, 1);
    n_checks++;
    if (ia.down_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_single: got %0b expected 0", ia.down_valid);
    end
  endtask

  task automatic test_count_saturation();
    do_reset();
    for (int i = 0; i < 300; i++) step(1, 0, 1, 1);
    step(1, 1, 1, 1);
    n_checks++;
    if (ia.down_valid !== 1'b1 || ia.down_count !== 8'd255 || ia.down_sum !== 16'd301 ||
        ia.down_overflow !== 1'b0 || ia.down_max !== 8'd1) begin
      n_fail++; $display("FAIL sat_wide: got v=%0b cnt=%0d sum=%0d ovf=%0b max=%0d expected 1 255 301 0 1",
                         ia.down_valid, ia.down_count, ia.down_sum, ia.down_overflow, ia.down_max);
    end
    n_checks++;
    if (ib.down_count !== 8'd255 || ib.down_sum !== 8'd45 || ib.down_overflow !== 1'b1) begin
      n_fail++; $display("FAIL sat_narrow: got cnt=%0d sum=%0d ovf=%0b expected 255 45 1",
                         ib.down_count, ib.down_sum, ib.down_overflow);
    end
  endtask

  task automatic test_random();
    rec_t ea, eb;
    bit   v, l, r;
    int   d;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 799) == 0) do_reset();
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 1) != 0) ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 255));
      if (((i / 200) % 2) == 1) r = ($urandom_range(0, 4) == 0);
      else r = ($urandom_range(0, 3) != 0);
      step(v, l, d, r);

      n_checks++;
      if (ia.down_valid !== (qa.size() != 0)) begin
        n_fail++; $display("FAIL rand_valid_a @%0d: got %0b expected %0b", i, ia.down_valid, qa.size() != 0);
      end
      if (qa.size() != 0) begin
        ea = qa[0];
        n_checks++;
        if (ia.down_sum !== 16'(ea.sum) || ia.down_count !== 8'(ea.cnt) ||
            ia.down_max !== 8'(ea.mx) || ia.down_overflow !== ea.ovf) begin
          n_fail++; $display("FAIL rand_rec_a @%0d: got %0d/%0d/%0d/%0b expected %0d/%0d/%0d/%0b", i,
                             ia.down_sum, ia.down_count, ia.down_max, ia.down_overflow,
                             ea.sum, ea.cnt, ea.mx, ea.ovf);
        end
      end
      n_checks++;
      if (drop_a !== 8'(exp_drop_a)) begin
        n_fail++; $display("FAIL rand_drop_a @%0d: got %0d expected %0d", i, drop_a, exp_drop_a);
      end

      n_checks++;
      if (ib.down_valid !== (qb.size() != 0)) begin
        n_fail++; $display("FAIL rand_valid_b @%0d: got %0b expected %0b", i, ib.down_valid, qb.size() != 0);
      end
      if (qb.size() != 0) begin
        eb = qb[0];
        n_checks++;
        if (ib.down_sum !== 8'(eb.sum) || ib.down_count !== 8'(eb.cnt) ||
            ib.down_max !== 8'(eb.mx) || ib.down_overflow !== eb.ovf) begin
          n_fail++; $display("FAIL rand_rec_b @%0d: got %0d/%0d/%0d/%0b expected %0d/%0d/%0d/%0b", i,
                             ib.down_sum, ib.down_count, ib.down_max, ib.down_overflow,
                             eb.sum, eb.cnt, eb.mx, eb.ovf);
        end
      end
      n_checks++;
      if (drop_b !== 8'(exp_drop_b)) begin
        n_fail++; $display("FAIL rand_drop_b @%0d: got %0d expected %0d", i, drop_b, exp_drop_b);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0);
    test_reset();
    test_basic();
    test_overflow();
    test_drop();
    test_full_pop_push();
    test_reset_mid_packet();
    test_count_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
